regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write, two-read register file in the core.
- Adds configurable width, depth and read-port count, and a second write port for the late/load writeback path.
- Adds optional write-to-read bypass and a per-register pending-write scoreboard used by issue logic for RAW hazard detection.
- Sits between decode/issue (read, scoreboard set) and the writeback stage (write, scoreboard clear).

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; power of 2, at least 2.
- NUM_RD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = writes visible next cycle.
- AW, $clog2(NUM_REGS), address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i is bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data, combinational.
- rd_busy  out  NUM_RD  pending-write flag per read port, combinational.
- we0  in  1  write enable, port 0 (ALU writeback).
- waddr0  in  AW  write address, port 0.
- wdata0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (load/late writeback).
- waddr1  in  AW  write address, port 1.
- wdata1  in  XLEN  write data, port 1.
- sb_set  in  1  mark a register pending (instruction issued).
- sb_addr  in  AW  register to mark pending.
- busy_vec  out  NUM_REGS  full scoreboard state, registered.

Behaviour:
- Reset:
  - reset low asynchronously clears every register and every busy bit to 0; busy_vec = 0.
  - rd_data and rd_busy then reflect zeros.
  - Reset asserted mid-operation discards any in-flight write or set in that cycle.
- Register 0:
  - Hardwired zero. Writes to it are ignored, it is never set busy.
  - Reads of it return 0 and rd_busy = 0, including under bypass.
- Writes:
  - Taken on the rising edge when weN=1 and waddrN!=0.
  - Both ports writing the same address in one cycle: port 1 wins (later pipeline stage, younger value).
- Reads:
  - Combinational from array state.
  - If BYPASS=1 and a write to the read address is active this cycle, rd_data returns the write data, with port 1 having priority over port 0.
  - If BYPASS=0, reads return the pre-edge array value.
- Scoreboard:
  - Busy bit r is set on the edge when sb_set=1 and sb_addr=r (r!=0).
  - It is cleared on the edge when either write port writes r.
  - Same-cycle set and clear of the same r: set wins (new producer issued).
  - sb_set on an already-busy register keeps it busy; no counting.
- rd_busy[i]:
  - Equals busy_vec[rd_addr_i].
  - With BYPASS=1 it is masked to 0 when a same-cycle write to that address is active.
- Latency:
  - Write to read: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - Set to busy: 1 cycle.
- Storage: flop array, no reset-walk FSM; every read port indexes independently.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN and NUM_REGS constants.
  - ZERO_REG localparam = 0.
  - Write-port priority constant.
- Sub-module regfile_scoreboard:
  - Holds busy bits, set/clear logic and set-wins rule.
  - Outputs busy_vec.
- regfile_mp instantiates it and adds the array, bypass muxing and rd_busy masking.

Test Plan:
- Reset: preload r5=0xDEADBEEF and busy(r5)=1, pull reset low mid-cycle -> rd_data(r5)=0 and busy_vec=0 immediately, before the next clock edge.
- x0: we0=1, waddr0=0, wdata0=0x1234, sb_set=1, sb_addr=0 -> rd_data(r0)=0, rd_busy=0, busy_vec[0]=0 next cycle.
- Dual-write collision: we0 (r7, 0x11111111) and we1 (r7, 0x22222222) in one cycle -> next cycle r7=0x22222222. With BYPASS=1, same-cycle read of r7 returns 0x22222222.
- Bypass off vs on: r3=0xA; write r3=0xB; read r3 in the write cycle -> 0xA with BYPASS=0, 0xB with BYPASS=1. Both configurations read 0xB the next cycle.
- Scoreboard set-wins: busy(r9)=1; same cycle we1 writes r9 and sb_set on r9 -> busy_vec[9]=1 after the edge. Repeat without sb_set -> busy_vec[9]=0.
- Multi-port: NUM_RD=3, read r1/r2/r1 with r1=0x5 and r2=0x6 -> rd_data = {0x5, 0x6, 0x5}. rd_busy per port matches busy_vec.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default sizes, the hardwired
// zero register and which write port wins an address collision.
package regfile_pkg;

  localparam int unsigned DEFAULT_XLEN     = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 32;
  localparam int unsigned ZERO_REG         = 0;

  typedef enum logic {
    WpPort0,
    WpPort1
  } wport_e;

  // Port 1 carries the later pipeline stage, so its value is the younger one.
  localparam wport_e WRITE_PRIO = WpPort1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: set at issue, cleared at writeback, set wins on a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (we0 && waddr0 == AW'(r)) busy_d[r] = 1'b0;
      if (we1 && waddr1 == AW'(r)) busy_d[r] = 1'b0;
      // Applied after the clears: a newly issued producer owns the register.
      if (sb_set && sb_addr == AW'(r)) busy_d[r] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NUM_RD combinational read ports,
// optional write-to-read bypass and a pending-write scoreboard for RAW detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = DEFAULT_XLEN,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   we0,
  input  logic [AW-1:0]          waddr0,
  input  logic [XLEN-1:0]        wdata0,
  input  logic                   we1,
  input  logic [AW-1:0]          waddr1,
  input  logic [XLEN-1:0]        wdata1,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_addr,
  output logic [NUM_REGS-1:0]    busy_vec
);

  localparam logic PORT1_WINS = (WRITE_PRIO == WpPort1);

  logic [XLEN-1:0] mem [NUM_REGS];

  // Entry 0 is cleared by reset and never written, so it synthesises to a constant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (we0 && waddr0 == AW'(r) && we1 && waddr1 == AW'(r)) begin
          mem[r] <= PORT1_WINS ? wdata1 : wdata0;
        end else if (we1 && waddr1 == AW'(r)) begin
          mem[r] <= wdata1;
        end else if (we0 && waddr0 == AW'(r)) begin
          mem[r] <= wdata0;
        end
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .we0      (we0),
    .waddr0   (waddr0),
    .we1      (we1),
    .waddr1   (waddr1),
    .busy_vec (busy_vec)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;
    logic            hit0, hit1;

    assign addr = rd_addr[i*AW +: AW];
    assign hit0 = we0 && waddr0 == addr;
    assign hit1 = we1 && waddr1 == addr;

    always_comb begin
      data = mem[addr];
      busy = busy_vec[addr];
      if (BYPASS != 0) begin
        if (hit0 && hit1) begin
          data = PORT1_WINS ? wdata1 : wdata0;
          busy = 1'b0;
        end else if (hit1) begin
          data = wdata1;
          busy = 1'b0;
        end else if (hit0) begin
          data = wdata0;
          busy = 1'b0;
        end
      end
      if (addr == AW'(ZERO_REG)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data;
    assign rd_busy[i]              = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus,
// expected values are queued at drive time and popped when the outputs are sampled.
module tb_regfile_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NR   = 32;
  localparam int unsigned NRD  = 3;
  localparam int unsigned AW   = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NRD*AW-1:0]     rd_addr;
  logic                  we0, we1, sb_set;
  logic [AW-1:0]         waddr0, waddr1, sb_addr;
  logic [XLEN-1:0]       wdata0, wdata1;
  logic [NRD*XLEN-1:0]   rd_data_b, rd_data_n;
  logic [NRD-1:0]        rd_busy_b, rd_busy_n;
  logic [NR-1:0]         busy_vec_b, busy_vec_n;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1),
    .wdata1(wdata1), .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_vec_b)
  );

  regfile_mp #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1),
    .wdata1(wdata1), .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_vec_n)
  );

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void push(input string tag, input logic [127:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    q.push_back(e);
  endfunction

  task automatic pop_check(input logic [127:0] observed);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %0h required a queued expectation", observed);
    end else begin
      e = q.pop_front();
      assert (observed === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h required %0h", e.tag, observed, e.val);
      end
    end
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; sb_set = 0;
    waddr0 = '0; waddr1 = '0; sb_addr = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic rd3(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    rd3(1, 2, 3);
    #12;
    push("reset_busy_vec", '0);
    pop_check(128'(busy_vec_b));
    push("reset_rd_data", '0);
    pop_check(128'(rd_data_n));
    reset = 1'b1;

    // Preload r5 with data and mark it pending in the same cycle (set wins).
    step();
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; sb_set = 1; sb_addr = 5;
    step();
    idle();
    rd3(5, 5, 5);
    #2;
    push("preload_r5", {32'h0, {3{32'hDEADBEEF}}});
    pop_check(128'(rd_data_n));
    push("preload_busy5", 128'(32'h0000_0020));
    pop_check(128'(busy_vec_b));
    push("preload_rd_busy", 128'(3'b111));
    pop_check(128'(rd_busy_b));

    // Mid-cycle asynchronous reset.
    reset = 1'b0;
    #1;
    push("async_rst_rd_data_b", '0);
    pop_check(128'(rd_data_b));
    push("async_rst_rd_data_n", '0);
    pop_check(128'(rd_data_n));
    push("async_rst_busy_vec", '0);
    pop_check(128'({busy_vec_b, busy_vec_n}));
    reset = 1'b1;

    // Writes and sets to r0 are ignored, even under bypass.
    step();
    we0 = 1; waddr0 = 0; wdata0 = 32'h1234; sb_set = 1; sb_addr = 0;
    we1 = 1; waddr1 = 0; wdata1 = 32'h5678;
    rd3(0, 0, 0);
    #1;
    push("x0_bypass_data", '0);
    pop_check(128'(rd_data_b));
    push("x0_bypass_busy", '0);
    pop_check(128'(rd_busy_b));
    step();
    idle();
    #1;
    push("x0_busy_vec", '0);
    pop_check(128'({busy_vec_b, busy_vec_n}));
    push("x0_read_after", '0);
    pop_check(128'({rd_data_b, rd_data_n}));

    // Dual-write collision on r7: port 1 wins.
    we0 = 1; waddr0 = 7; wdata0 = 32'h11111111;
    we1 = 1; waddr1 = 7; wdata1 = 32'h22222222;
    rd3(7, 0, 0);
    #1;
    push("collide_bypass", 128'(32'h22222222));
    pop_check(128'(rd_data_b[31:0]));
    push("collide_nobypass_old", '0);
    pop_check(128'(rd_data_n[31:0]));
    step();
    idle();
    #1;
    push("collide_after", {64'h0, 32'h22222222, 32'h22222222});
    pop_check(128'({rd_data_b[31:0], rd_data_n[31:0]}));

    // Bypass off vs on.
    we0 = 1; waddr0 = 3; wdata0 = 32'hA;
    step();
    we0 = 1; waddr0 = 3; wdata0 = 32'hB;
    rd3(3, 3, 3);
    #1;
    push("bypass_on_new", {32'h0, {3{32'hB}}});
    pop_check(128'(rd_data_b));
    push("bypass_off_old", {32'h0, {3{32'hA}}});
    pop_check(128'(rd_data_n));
    step();
    idle();
    #1;
    push("bypass_after", {64'h0, 32'hB, 32'hB});
    pop_check(128'({rd_data_b[31:0], rd_data_n[31:0]}));

    // Scoreboard: set, re-set, set-wins against a clear, then a plain clear.
    sb_set = 1; sb_addr = 9;
    step();
    sb_set = 1; sb_addr = 9;
    rd3(9, 0, 9);
    #1;
    push("sb_set_busy", 128'({2'b11, 32'h0000_0200}));
    pop_check(128'({rd_busy_n[0], rd_busy_n[2], busy_vec_n}));
    step();
    idle();
    we1 = 1; waddr1 = 9; wdata1 = 32'h99; sb_set = 1; sb_addr = 9;
    #1;
    push("sb_bypass_mask", 128'({3'b000, 3'b101}));
    pop_check(128'({rd_busy_b, rd_busy_n}));
    step();
    idle();
    #1;
    push("sb_set_wins", 128'({32'h0000_0200, 32'h0000_0200}));
    pop_check(128'({busy_vec_b, busy_vec_n}));
    we1 = 1; waddr1 = 9; wdata1 = 32'h9A;
    step();
    idle();
    #1;
    push("sb_clear", '0);
    pop_check(128'({busy_vec_b, busy_vec_n}));
    push("sb_clear_data", 128'(32'h9A));
    pop_check(128'(rd_data_n[31:0]));

    // Multi-port reads with r2 pending.
    we0 = 1; waddr0 = 1; wdata0 = 32'h5;
    we1 = 1; waddr1 = 2; wdata1 = 32'h6;
    sb_set = 1; sb_addr = 2;
    step();
    idle();
    rd3(1, 2, 1);
    #1;
    push("multi_rd_data_b", {32'h0, 32'h5, 32'h6, 32'h5});
    pop_check(128'(rd_data_b));
    push("multi_rd_data_n", {32'h0, 32'h5, 32'h6, 32'h5});
    pop_check(128'(rd_data_n));
    push("multi_rd_busy", 128'({3'b010, 3'b010}));
    pop_check(128'({rd_busy_b, rd_busy_n}));
    push("multi_busy_vec", 128'(32'h0000_0004));
    pop_check(128'(busy_vec_b));

    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: observed %0d required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
